ps2rx_frame: RTL
================

// Module: ps2rx_frame
// PURPOSE
//  Host-side PS/2 receiver for device-to-host frames from the keyboard.
//  - Synchronises and deglitches ps2_clk and ps2_data.
//  - Samples ps2_data on falling edges of the filtered clock.
//  - Checks start, odd parity and stop bits, then presents the byte with a 1-cycle strobe.
//  - Pairs with the host-to-device transmitter; that block's write/busy output drives inhibit.
// PARAMETERS
//  FILTER_LEN      4      consecutive equal samples before a filtered line changes (1..15)
//  TIMEOUT_CYCLES  12500  idle clk cycles mid-frame before abort (~500us @25MHz), 16-bit
// PORTS
//  clk       in   1  system clock
//  reset     in   1  synchronous, active-high reset
//  ps2_clk   in   1  raw PS/2 clock pin (asynchronous, idle high)
//  ps2_data  in   1  raw PS/2 data pin (asynchronous, idle high)
//  inhibit   in   1  high while the host transmits; receiver held idle
//  q         out  8  last good received byte
//  rdy       out  1  1-cycle strobe: q updated with a good byte
//  perr      out  1  1-cycle strobe: parity error, q unchanged
//  ferr      out  1  1-cycle strobe: framing error (bad stop bit or timeout)
//  busy      out  1  high while a frame is in progress (bitcnt != 0)
// BEHAVIOUR
//  Reset values
//  - q=0; rdy=perr=ferr=busy=0; bitcnt=0.
//  - Sync flops and filtered lines = 1.
//  - Reset mid-frame: abort silently, no strobes.
//  Input conditioning
//  - Each pin passes through a 2-FF synchroniser.
//  - Filtered line takes the new value after FILTER_LEN consecutive equal synced samples.
//  - Glitches shorter than FILTER_LEN cycles are rejected.
//  - fall = filtered clk 1->0, detected for one cycle.
//  Frame FSM (bitcnt 0..10), on each fall
//  - 0 IDLE: data=0 -> bitcnt=1. data=1 -> false start, stay IDLE, no strobe.
//  - 1..8 DATA: shift data in LSB first into an 8-bit shift register.
//  - 9 PARITY: store bit; good when XOR(8 data bits, parity) = 1 (odd parity).
//  - 10 STOP: evaluate the frame, then return to bitcnt=0.
//  Stop evaluation
//  - stop=1, parity good: q <= shift register, rdy=1.
//  - stop=1, parity bad: perr=1.
//  - stop=0: ferr=1 (wins over perr).
//  - Strobes are registered: asserted the cycle after the stop-bit fall cycle, exactly 1 cycle wide.
//  - Latency from raw stop-bit clock fall to strobe = 2 + FILTER_LEN + 1 cycles.
//  Inhibit
//  - While inhibit=1: bitcnt forced to 0, falls ignored, no strobes.
//  - Filters keep tracking the pins.
//  - inhibit rising in the stop-bit fall cycle: inhibit wins, no strobe.
//  - Edges seen while inhibited are never replayed after release.
//  Back-to-back frames
//  - A start bit may arrive on the fall directly after a stop, with no idle gap.
// CONFIGURATION
//  PS2RX_TIMEOUT_EN defined
//  - 16-bit watchdog clears on every fall and counts while busy.
//  - Reaching TIMEOUT_CYCLES: bitcnt=0 and ferr pulses once, the cycle after the terminal count.
//  - A fall in that same cycle is treated as a fall in IDLE.
//  PS2RX_TIMEOUT_EN undefined
//  - No watchdog; a partial frame waits indefinitely.
//  - ferr comes only from a bad stop bit.
// TESTING
//  - Frame 0x1C, parity 0, stop 1, 40us clock half-period -> rdy pulse 1 cycle, q=0x1C, perr=ferr=0.
//  - Frame 0xF0 with parity 0 (bad) -> perr pulse, q keeps previous 0x1C, no rdy.
//  - Frame 0x5A with stop 0 -> ferr pulse, no rdy, busy falls; next good 0x12 frame -> q=0x12.
//  - 2-cycle low glitch on ps2_clk while idle -> no state change, busy stays 0.
//  - inhibit=1 across a full 0x29 frame -> no strobes, q unchanged, busy=0 throughout.
//  - With PS2RX_TIMEOUT_EN: stop the clock after 4 data bits -> ferr after TIMEOUT_CYCLES, busy=0;
//    following frame 0x76 -> rdy, q=0x76.

Source files
------------

// File: rtl/ps2rx_frame.sv
// ---------------------------------------------------------------------------
// ps2rx_frame
// Host-side PS/2 receiver for device-to-host keyboard frames.
//
// Both PS/2 pins pass through a 2-FF synchroniser and a glitch filter. On
// every falling edge of the filtered clock, the receiver samples the filtered
// data line. It collects the start bit, 8 data bits (LSB first), the odd
// parity bit and the stop bit, then reports the result with a one-cycle
// strobe.
//
// Parameters
//   FILTER_LEN      consecutive equal synced samples before a filtered line
//                   changes (1..15)
//   TIMEOUT_CYCLES  idle clk cycles mid-frame before the frame is aborted
//                   (16-bit; used only with PS2RX_TIMEOUT_EN)
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   ps2_clk   in   raw PS/2 clock pin (asynchronous, idle high)
//   ps2_data  in   raw PS/2 data pin (asynchronous, idle high)
//   inhibit   in   high while the host transmits; holds the receiver idle
//   q         out  last good received byte
//   rdy       out  1-cycle strobe: q updated with a good byte
//   perr      out  1-cycle strobe: parity error, q unchanged
//   ferr      out  1-cycle strobe: framing error (bad stop bit or timeout)
//   busy      out  high while a frame is in progress
//
// Configuration macro
//   PS2RX_TIMEOUT_EN  when defined, a 16-bit mid-frame watchdog aborts a
//                     stalled frame with an ferr strobe. When undefined, a
//                     partial frame waits indefinitely.
// ---------------------------------------------------------------------------
module ps2rx_frame #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 12500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       inhibit,
  output logic [7:0] q,
  output logic       rdy,
  output logic       perr,
  output logic       ferr,
  output logic       busy
);

  localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [15:0] WDOG_TC   = 16'(TIMEOUT_CYCLES);

  // Odd parity: the 8 data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // One filter step. Returns {next filtered value, next run counter}. The
  // line flips only after FILTER_LEN consecutive samples that differ from it.
  function automatic logic [4:0] filter_step(input logic sync, input logic filt,
                                             input logic [3:0] cnt);
    logic [4:0] r;
    if (sync == filt) begin
      r = {filt, 4'd0};
    end else if (cnt == FILT_LAST) begin
      r = {sync, 4'd0};
    end else begin
      r = {filt, cnt + 4'd1};
    end
    return r;
  endfunction

  // Input conditioning state
  logic       clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic       dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic       clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic [3:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
  logic       clk_prev_q, clk_prev_d;
  logic       fall_s;

  // Frame state
  logic [3:0] bitcnt_q, bitcnt_d, cnt_s;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] q_q, q_d;
  logic       rdy_q, rdy_d, perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;
  logic       timeout_s;

`ifdef PS2RX_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^WDOG_TC;
`endif

  // Synchronisers, glitch filters and falling-edge detect on the filtered clock.
  always_comb begin
    clk_meta_d = ps2_clk;
    clk_sync_d = clk_meta_q;
    dat_meta_d = ps2_data;
    dat_sync_d = dat_meta_q;
    {clk_filt_d, clk_cnt_d} = filter_step(clk_sync_q, clk_filt_q, clk_cnt_q);
    {dat_filt_d, dat_cnt_d} = filter_step(dat_sync_q, dat_filt_q, dat_cnt_q);
    clk_prev_d = clk_filt_q;
    fall_s     = clk_prev_q & ~clk_filt_q;
  end

  // Frame sequencer: bitcnt 0 idle, 1..8 data, 9 parity, 10 stop.
  always_comb begin
    timeout_s = 1'b0;
`ifdef PS2RX_TIMEOUT_EN
    if ((bitcnt_q != 4'd0) && (wdog_q == WDOG_TC)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    // The watchdog only runs between falls of an active, uninhibited frame.
    if (timeout_s || fall_s || inhibit || (bitcnt_q == 4'd0)) begin
      wdog_d = 16'd0;
    end else begin
      wdog_d = wdog_q + 16'd1;
    end
`endif
    // A timeout drops the frame first, so a coincident fall is treated as a fall in idle.
    cnt_s    = timeout_s ? 4'd0 : bitcnt_q;
    bitcnt_d = cnt_s;
    shift_d  = shift_q;
    par_d    = par_q;
    q_d      = q_q;
    rdy_d    = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = timeout_s;
    if (inhibit) begin
      // Inhibit overrides everything, including a stop bit in the same cycle.
      bitcnt_d = 4'd0;
      ferr_d   = 1'b0;
    end else if (fall_s) begin
      case (cnt_s)
        4'd0: begin
          // A high data line here is a false start.
          if (!dat_filt_q) begin
            bitcnt_d = 4'd1;
          end else begin
            bitcnt_d = 4'd0;
          end
        end
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          shift_d  = {dat_filt_q, shift_q[7:1]};
          bitcnt_d = cnt_s + 4'd1;
        end
        4'd9: begin
          par_d    = dat_filt_q;
          bitcnt_d = 4'd10;
        end
        4'd10: begin
          bitcnt_d = 4'd0;
          if (!dat_filt_q) begin
            ferr_d = 1'b1;
          end else if (odd_parity_ok(shift_q, par_q)) begin
            q_d   = shift_q;
            rdy_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: begin
          bitcnt_d = 4'd0;
        end
      endcase
    end else begin
      bitcnt_d = cnt_s;
    end
    busy_d = (bitcnt_d != 4'd0);
  end

  // State registers; the lines reset to their idle-high level.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      clk_cnt_q  <= 4'd0;
      dat_cnt_q  <= 4'd0;
      clk_prev_q <= 1'b1;
      bitcnt_q   <= 4'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      q_q        <= 8'd0;
      rdy_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PS2RX_TIMEOUT_EN
      wdog_q     <= 16'd0;
`endif
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      clk_filt_q <= clk_filt_d;
      dat_filt_q <= dat_filt_d;
      clk_cnt_q  <= clk_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
      clk_prev_q <= clk_prev_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      q_q        <= q_d;
      rdy_q      <= rdy_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef PS2RX_TIMEOUT_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign q    = q_q;
  assign rdy  = rdy_q;
  assign perr = perr_q;
  assign ferr = ferr_q;
  assign busy = busy_q;

endmodule
